// File: rtl/instruction_fetch_if.sv
// Fetch-side bus bundle: program-memory read port plus the CPU instruction
// register / start strobe / waiting-flag handshake.
interface instruction_fetch_if;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic [15:0] cpu_in;
    logic        cpu_load;
    logic        cpu_s;
    logic        cpu_w;

    modport master (
        output mem_addr, mem_rd, cpu_in, cpu_load, cpu_s,
        input  mem_rdata, mem_valid, cpu_w
    );

    modport slave (
        input  mem_addr, mem_rd, cpu_in, cpu_load, cpu_s,
        output mem_rdata, mem_valid, cpu_w
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: reads program words at pc, hands each one to the
// CPU core (load, then start strobe) and waits for the core before fetching again.
module instruction_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    instruction_fetch_if.master bus,
    output logic [7:0]          pc,
    output logic                halted,
    output logic [15:0]         icount
);
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        EXEC,
        HALTED
    } state_t;

    state_t state;

    // NOTE: every register here uses <= so all state updates on an edge see the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            bus.mem_addr <= RESET_PC;
            bus.mem_rd   <= 1'b0;
            bus.cpu_in   <= 16'h0000;
            bus.cpu_load <= 1'b0;
            bus.cpu_s    <= 1'b0;
            halted       <= 1'b0;
            icount       <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= FETCH;
                        bus.mem_rd   <= 1'b1;
                        bus.mem_addr <= pc;
                    end
                end

                // mem_rd is always high in FETCH, so mem_valid needs no extra qualifier.
                FETCH: begin
                    if (bus.mem_valid) begin
                        bus.mem_rd <= 1'b0;
                        if (bus.mem_rdata[15:13] == OP_HALT) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            state        <= LOAD;
                            bus.cpu_in   <= bus.mem_rdata;
                            bus.cpu_load <= 1'b1;
                            pc           <= pc + 8'd1;
                        end
                    end
                end

                LOAD: begin
                    state        <= START;
                    bus.cpu_load <= 1'b0;
                    bus.cpu_s    <= 1'b1;
                end

                START: begin
                    state     <= EXEC;
                    bus.cpu_s <= 1'b0;
                end

                // The core drops w on the edge leaving START, so a stale w=1 is never seen here.
                EXEC: begin
                    if (bus.cpu_w) begin
                        state        <= FETCH;
                        bus.mem_rd   <= 1'b1;
                        bus.mem_addr <= pc;
                        if (icount != 16'hFFFF) begin
                            icount <= icount + 16'd1;
                        end
                    end
                end

                HALTED: begin
                    if (start) begin
                        state        <= FETCH;
                        pc           <= RESET_PC;
                        bus.mem_addr <= RESET_PC;
                        bus.mem_rd   <= 1'b1;
                        halted       <= 1'b0;
                        icount       <= 16'h0000;
                    end
                end

                default: begin
                    state        <= IDLE;
                    bus.mem_rd   <= 1'b0;
                    bus.cpu_load <= 1'b0;
                    bus.cpu_s    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: two instances (RESET_PC 00 and FE) with memory
// and CPU responders, checked against a program-walk reference model.
module tb_instruction_fetch;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        start_i [2] = '{1'b0, 1'b0};
    logic [7:0]  pc_o     [2];
    logic        halted_o [2];
    logic [15:0] icount_o [2];
    logic        rd_o     [2];
    logic        ld_o     [2];
    logic        s_o      [2];
    logic        valid_o  [2];
    logic        w_o      [2];
    logic [7:0]  addr_o   [2];
    logic [15:0] in_o     [2];

    logic [15:0] mem [2][256];
    int          mem_lat  [2] = '{0, 0};
    int          cpu_busy [2] = '{1, 1};
    logic        mem_hold    [2] = '{1'b0, 1'b0};
    logic        force_valid [2] = '{1'b0, 1'b0};

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 2; g++) begin : u
        instruction_fetch_if bus ();
        int wcnt     = 0;
        int busy_cnt = 0;

        instruction_fetch #(.RESET_PC((g == 0) ? 8'h00 : 8'hFE)) dut (
            .clk    (clk),
            .reset  (reset),
            .start  (start_i[g]),
            .bus    (bus),
            .pc     (pc_o[g]),
            .halted (halted_o[g]),
            .icount (icount_o[g])
        );

        // Memory answers after mem_lat cycles; the CPU drops w after its start
        // strobe and raises it again cpu_busy cycles later.
        always @(negedge clk) begin
            if (mem_hold[g]) begin
                bus.mem_valid = force_valid[g];
                bus.mem_rdata = mem[g][bus.mem_addr];
            end else if (bus.mem_rd === 1'b1) begin
                if (wcnt >= mem_lat[g]) begin
                    bus.mem_valid = 1'b1;
                    bus.mem_rdata = mem[g][bus.mem_addr];
                end else begin
                    bus.mem_valid = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.mem_valid = 1'b0;
                bus.mem_rdata = 16'h0000;
                wcnt = 0;
            end
            if (bus.cpu_s === 1'b1) begin
                bus.cpu_w = 1'b0;
                busy_cnt  = cpu_busy[g];
            end else begin
                if (busy_cnt > 0) busy_cnt--;
                if (busy_cnt == 0) bus.cpu_w = 1'b1;
            end
        end

        assign rd_o[g]    = bus.mem_rd;
        assign ld_o[g]    = bus.cpu_load;
        assign s_o[g]     = bus.cpu_s;
        assign valid_o[g] = bus.mem_valid;
        assign w_o[g]     = bus.cpu_w;
        assign addr_o[g]  = bus.mem_addr;
        assign in_o[g]    = bus.cpu_in;
    end

    function automatic logic [7:0] rpc(input int d);
        return (d == 0) ? 8'h00 : 8'hFE;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int d);
        check("rst_mem_rd",   32'(rd_o[d]),     32'(0));
        check("rst_mem_addr", 32'(addr_o[d]),   32'(rpc(d)));
        check("rst_cpu_in",   32'(in_o[d]),     32'(0));
        check("rst_cpu_load", 32'(ld_o[d]),     32'(0));
        check("rst_cpu_s",    32'(s_o[d]),      32'(0));
        check("rst_pc",       32'(pc_o[d]),     32'(rpc(d)));
        check("rst_halted",   32'(halted_o[d]), 32'(0));
        check("rst_icount",   32'(icount_o[d]), 32'(0));
    endtask

    task automatic load_prog(input int d, input int n);
        logic [15:0] w;
        logic [7:0]  a;
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            if (w[15:13] == 3'b111) w[15] = 1'b0;
            a = rpc(d) + 8'(i);
            mem[d][a] = w;
        end
        a = rpc(d) + 8'(n);
        mem[d][a] = {3'b111, 13'($urandom)};
    endtask

    // Pulse start, watch the fetch run to its halt, then compare against the
    // program walked from RESET_PC and the latencies implied by lat/busy.
    task automatic run(input int d, input int lat, input int busy);
        logic [15:0] words[$];
        logic [7:0]  addrs[$];
        int          s_cyc[$];
        logic [15:0] exp_words[$];
        logic [7:0]  exp_addrs[$];
        logic [7:0]  p;
        int          cyc = 0;
        int          first_ld = -1;
        int          rd_cycles = 0;
        logic        prev_rd = 1'b0;
        logic        prev_ld = 1'b0;

        p = rpc(d);
        for (int i = 0; i < 256; i++) begin
            exp_addrs.push_back(p);
            if (mem[d][p][15:13] == 3'b111) break;
            exp_words.push_back(mem[d][p]);
            p = p + 8'd1;
        end

        mem_lat[d]  = lat;
        cpu_busy[d] = busy;
        @(negedge clk);
        start_i[d] = 1'b1;
        @(posedge clk);
        #1;
        start_i[d] = 1'b0;
        check("start_mem_rd",   32'(rd_o[d]),     32'(1));
        check("start_mem_addr", 32'(addr_o[d]),   32'(rpc(d)));
        check("start_halted",   32'(halted_o[d]), 32'(0));
        check("start_icount",   32'(icount_o[d]), 32'(0));

        while (cyc < 2000) begin
            if (ld_o[d] || s_o[d]) check("load_s_exclusive", 32'(ld_o[d] & s_o[d]), 32'(0));
            if (rd_o[d]) begin
                rd_cycles++;
                check("addr_eq_pc", 32'(addr_o[d]), 32'(pc_o[d]));
                if (!prev_rd) addrs.push_back(addr_o[d]);
            end
            if (ld_o[d]) begin
                check("load_after_accept", 32'(prev_rd & valid_o[d]), 32'(1));
                words.push_back(in_o[d]);
                if (first_ld < 0) first_ld = cyc;
            end
            if (s_o[d]) begin
                check("s_after_load", 32'(prev_ld), 32'(1));
                s_cyc.push_back(cyc);
            end
            prev_rd = rd_o[d];
            prev_ld = ld_o[d];
            if (halted_o[d]) break;
            // start is wiggled only while the core is busy, i.e. during EXEC
            start_i[d] = (w_o[d] === 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        start_i[d] = 1'b0;

        check("halt_reached", 32'(halted_o[d]), 32'(1));
        check("n_loads", words.size(), exp_words.size());
        for (int i = 0; i < words.size() && i < exp_words.size(); i++)
            check("cpu_in_word", 32'(words[i]), 32'(exp_words[i]));
        check("n_fetches", addrs.size(), exp_addrs.size());
        for (int i = 0; i < addrs.size() && i < exp_addrs.size(); i++)
            check("fetch_addr", 32'(addrs[i]), 32'(exp_addrs[i]));
        check("halt_pc",     32'(pc_o[d]),     32'(p));
        check("halt_icount", 32'(icount_o[d]), exp_words.size());
        check("halt_mem_rd", 32'(rd_o[d]),     32'(0));
        check("rd_cycles",   rd_cycles,        (exp_addrs.size()) * (lat + 1));
        if (exp_words.size() > 0) begin
            check("first_load_cycle", first_ld, lat + 1);
            check("n_strobes", s_cyc.size(), exp_words.size());
            if (s_cyc.size() > 0) check("first_s_cycle", s_cyc[0], lat + 2);
            for (int i = 1; i < s_cyc.size(); i++)
                check("s_to_s_cycles", s_cyc[i] - s_cyc[i-1], busy + 3 + lat);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 256; a++) mem[d][a] = 16'hE000;

        // reset and idle
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        reset = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("idle_mem_rd0", 32'(rd_o[0]), 32'(0));
            check("idle_mem_rd1", 32'(rd_o[1]), 32'(0));
        end
        check_reset(0);
        check_reset(1);

        // zero-wait program, then restart from HALTED with wait-state memory
        mem[0][0] = 16'hD105;
        mem[0][1] = 16'hD203;
        mem[0][2] = 16'hA161;
        mem[0][3] = 16'hE000;
        run(0, 0, 4);
        check("prog_pc",     32'(pc_o[0]),     32'(8'h03));
        check("prog_icount", 32'(icount_o[0]), 32'(3));
        run(0, 3, 4);

        // pc wraps FE, FF, 00 and halts at 01
        mem[1][8'hFE] = 16'h1111;
        mem[1][8'hFF] = 16'h2222;
        mem[1][8'h00] = 16'h4444;
        mem[1][8'h01] = 16'hE000;
        run(1, 1, 2);
        check("wrap_pc", 32'(pc_o[1]), 32'(8'h01));

        // reset in FETCH with the read outstanding, then a late mem_valid
        mem[0][0]  = 16'h1234;
        mem_lat[0] = 1000;
        @(negedge clk);
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        @(negedge clk);
        check("pre_reset_mem_rd", 32'(rd_o[0]), 32'(1));
        mem_hold[0]    = 1'b1;
        force_valid[0] = 1'b0;
        reset = 1'b0;
        #1;
        check_reset(0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        force_valid[0] = 1'b1;
        @(negedge clk);
        #1;
        force_valid[0] = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("late_valid_load",   32'(ld_o[0]),     32'(0));
            check("late_valid_mem_rd", 32'(rd_o[0]),     32'(0));
            check("late_valid_icount", 32'(icount_o[0]), 32'(0));
            check("late_valid_pc",     32'(pc_o[0]),     32'(0));
        end
        mem_hold[0] = 1'b0;

        // random programs on both instances
        for (int it = 0; it < 6; it++) begin
            int d;
            d = it % 2;
            load_prog(d, int'($urandom_range(0, 6)));
            run(d, int'($urandom_range(0, 3)), int'($urandom_range(1, 5)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch sequencer sitting directly upstream of the `cpu` core. It reads 16-bit instruction words from program memory at an 8-bit program counter, loads each word into the CPU instruction register, pulses the CPU start strobe, and waits for the CPU's `w` (waiting) flag before fetching the next word. Fetch stops on a halt instruction (opcode `3'b111`), and the block reports PC, halted status and retired-instruction count.

## Interface
- `RESET_PC`, default `8'h00`: PC value after reset and on restart from HALTED.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `start`  in  1  level; sampled in IDLE/HALTED to begin fetching.
- `mem_addr`  out  8  registered read address; equals `pc` whenever `mem_rd`=1.
- `mem_rd`  out  1  registered read request; held high until `mem_valid`.
- `mem_rdata`  in  16  read data; valid only when `mem_valid`=1 and `mem_rd`=1.
- `mem_valid`  in  1  read-complete strobe; may arrive in the same cycle `mem_rd` rises (zero-wait) or any number of cycles later; ignored when `mem_rd`=0.
- `cpu_in`  out  16  registered; last fetched instruction, drives CPU `in`.
- `cpu_load`  out  1  registered one-cycle pulse; drives CPU `load`.
- `cpu_s`  out  1  registered one-cycle pulse; drives CPU `s`.
- `cpu_w`  in  1  CPU waiting flag (1 = idle/finished).
- `pc`  out  8  current program counter.
- `halted`  out  1  high in HALTED state.
- `icount`  out  16  retired instructions; saturates at `16'hFFFF`.

## Operation
- States: IDLE, FETCH, LOAD, START, EXEC, HALTED. All outputs are registered and set on the edge entering the state.
- Reset (`reset`=0, asynchronous): state=IDLE, `pc`=`RESET_PC`, `mem_addr`=`RESET_PC`, `mem_rd`=0, `cpu_in`=0, `cpu_load`=0, `cpu_s`=0, `halted`=0, `icount`=0. Reset mid-operation abandons any outstanding read; a late `mem_valid` is ignored because `mem_rd`=0.
- IDLE: `start`=1 -> FETCH (`mem_rd`=1, `mem_addr`=`pc`).
- FETCH: hold `mem_rd`=1 until `mem_valid`=1. On valid:
  - `mem_rdata[15:13]`=`3'b111` -> HALTED; `mem_rd`=0, `halted`=1, `pc` unchanged (points at the halt word), no CPU strobes.
  - Otherwise -> LOAD; capture `cpu_in`=`mem_rdata`, `cpu_load`=1, `mem_rd`=0, `pc`=`pc`+1 modulo 256 (`8'hFF` wraps to `8'h00`).
- LOAD (one cycle, `cpu_load`=1) -> START; `cpu_load`=0, `cpu_s`=1.
- START (one cycle, `cpu_s`=1) -> EXEC; `cpu_s`=0.
- EXEC: wait for `cpu_w`=1. On `cpu_w`=1 -> FETCH; `icount`+1 (saturating), `mem_rd`=1, `mem_addr`=`pc`. `cpu_w`=0 stays in EXEC indefinitely; the block adds no timeout.
- HALTED: `start`=1 -> FETCH with `pc`=`mem_addr`=`RESET_PC`, `icount`=0, `halted`=0. `start`=0 holds.
- `start` is ignored in FETCH/LOAD/START/EXEC.
- `cpu_load` and `cpu_s` are never high in the same cycle, and never high outside LOAD/START.

## Timing
- `start` sampled high at edge k: `mem_rd`=1 from k.
- Zero-wait memory (`mem_valid` in first FETCH cycle): `cpu_load`=1 in cycle k+1, `cpu_s`=1 in cycle k+2, EXEC from k+3.
- Each memory wait cycle adds one cycle before LOAD.
- The CPU drops `w` on the edge ending START, so `cpu_w` reads 0 in the first EXEC cycle. EXEC therefore never accepts a stale `w`=1 from before the strobe.
- Back-to-back instructions: with zero-wait memory and the CPU finishing at edge m (`cpu_w`=1 sampled), the next `mem_rd`=1 is in cycle m, giving `cpu_s` in m+2.
- `pc` increments on the same edge that `cpu_in` is captured. `icount` increments on the EXEC->FETCH edge.

## Test plan
- Reset/idle: hold `reset`=0, then release with `start`=0 for 10 cycles -> all outputs at reset values, `pc`=`RESET_PC`, `mem_rd`=0 throughout.
- Zero-wait program: memory holds `16'hD105`, `16'hD203`, `16'hA161`, `16'hE000` at addresses 0-3; model `cpu_w` falling after `cpu_s` and rising 4 cycles later. Pulse `start` -> exactly three `cpu_load`/`cpu_s` pairs carrying those three words in order, then `halted`=1, `pc`=3, `icount`=3.
- Wait-state memory: `mem_valid` delayed 3 cycles -> `mem_rd` held high 4 cycles, `mem_addr` stable, `cpu_load` in the cycle after `mem_valid`.
- PC wrap: `RESET_PC`=`8'hFE`, non-halt words at FE/FF/00, halt at 01 -> fetch addresses FE, FF, 00, 01; `pc`=`8'h01` when halted.
- Reset mid-operation: assert `reset`=0 in FETCH with `mem_valid` pending, then drive `mem_valid`=1 one cycle after release -> no `cpu_load`, state IDLE, `icount`=0.
- Restart from HALTED: after the halt, `start`=1 -> `halted`=0, `icount`=0, first `mem_addr`=`RESET_PC`; `start` toggled during EXEC has no effect.
